// File: rtl/food_placer_if.sv
// ----------------------------------------------------------------------------
// food_placer_if
//   Bundles the signals between the food placer and its neighbours: the
//   random coordinate generators, the snake-body occupancy store, and the
//   renderer/collision logic.
//
//   master : the food placer itself
//   slave  : the environment (generators, occupancy store, consumers)
//
//   place_req  : single-cycle request for a new food position
//   rand_h/v   : raw random coordinates (8b / 7b)
//   rand_ce    : one-cycle advance pulse to both generators
//   occ_req    : occupancy query valid, occ_h/occ_v held while high
//   occ_ack    : query complete, occ_hit valid with it
//   food_h/v   : committed food cell, food_valid qualifies it
//   busy       : placement in progress
//   place_fail : one-cycle pulse, no free cell found
// ----------------------------------------------------------------------------
interface food_placer_if;
  logic       place_req;
  logic [7:0] rand_h;
  logic [6:0] rand_v;
  logic       rand_ce;
  logic       occ_req;
  logic [7:0] occ_h;
  logic [6:0] occ_v;
  logic       occ_ack;
  logic       occ_hit;
  logic [7:0] food_h;
  logic [6:0] food_v;
  logic       food_valid;
  logic       busy;
  logic       place_fail;

  modport master (
    input  place_req, rand_h, rand_v, occ_ack, occ_hit,
    output rand_ce, occ_req, occ_h, occ_v,
           food_h, food_v, food_valid, busy, place_fail
  );

  modport slave (
    output place_req, rand_h, rand_v, occ_ack, occ_hit,
    input  rand_ce, occ_req, occ_h, occ_v,
           food_h, food_v, food_valid, busy, place_fail
  );
endinterface

// File: rtl/food_placer.sv
// ----------------------------------------------------------------------------
// food_placer
//   Picks a free playfield cell for the next food item. On request it samples
//   the random generators, folds the pair into the playfield, asks the
//   occupancy store whether the cell is taken, and retries on a hit. After
//   MAX_TRIES random misses it either gives up (PLACE_FAIL pulse) or, when
//   FOOD_SCAN_FALLBACK_EN is defined, walks the playfield linearly from the
//   last candidate until a free cell turns up.
//
// Parameters
//   H_MAX     : largest horizontal cell index (2*(H_MAX+1) > 256)
//   V_MAX     : largest vertical cell index   (2*(V_MAX+1) > 128)
//   MAX_TRIES : random misses tolerated per placement (1..255)
//
// Ports
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   fp    : food_placer_if.master (request, generators, occupancy, result)
//
// Configuration macro
//   FOOD_SCAN_FALLBACK_EN : adds the SCAN state and linear-scan counters
// ----------------------------------------------------------------------------
module food_placer #(
  parameter int H_MAX     = 159,
  parameter int V_MAX     = 119,
  parameter int MAX_TRIES = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  food_placer_if.master fp
);

  localparam logic [7:0] H_MAX_L = 8'(H_MAX);
  localparam logic [7:0] H_SPAN  = 8'(H_MAX + 1);
  localparam logic [6:0] V_MAX_L = 7'(V_MAX);
  localparam logic [6:0] V_SPAN  = 7'(V_MAX + 1);
  localparam logic [7:0] TRIES_L = 8'(MAX_TRIES);

`ifdef FOOD_SCAN_FALLBACK_EN
  typedef enum logic [2:0] {S_IDLE, S_SAMPLE, S_QUERY, S_COMMIT, S_SCAN} state_e;
  localparam int CELLS = (H_MAX + 1) * (V_MAX + 1);
  localparam int SCW   = $clog2(CELLS + 1);
`else
  typedef enum logic [1:0] {S_IDLE, S_SAMPLE, S_QUERY, S_COMMIT} state_e;
`endif

  state_e     state_q, state_d;
  logic [7:0] cand_h_q;
  logic [6:0] cand_v_q;
  logic [7:0] tries_q;
  logic [7:0] food_h_q;
  logic [6:0] food_v_q;
  logic       food_valid_q;
  logic       place_fail_q;

  logic [7:0] fold_h;
  logic [6:0] fold_v;
  logic [7:0] tries_inc;
  logic       retry;
  logic       accept;
  logic       ack_ok;
  logic       fail_set;

  // One conditional subtract is enough because the raw range is below twice
  // the playfield span on each axis.
  assign fold_h = (fp.rand_h > H_MAX_L) ? fp.rand_h - H_SPAN : fp.rand_h;
  assign fold_v = (fp.rand_v > V_MAX_L) ? fp.rand_v - V_SPAN : fp.rand_v;

  assign tries_inc = (tries_q == 8'hFF) ? tries_q : tries_q + 8'd1;
  assign retry     = tries_inc < TRIES_L;
  assign accept    = (state_q == S_IDLE) && fp.place_req;
  // Acks are only meaningful while a query is outstanding.
  assign ack_ok    = (state_q == S_QUERY) && fp.occ_ack;

`ifdef FOOD_SCAN_FALLBACK_EN
  logic           scan_mode_q;
  logic [SCW-1:0] scan_cnt_q;
  logic           scan_done;
  logic [7:0]     step_h;
  logic [6:0]     step_v;

  // Raster step: H first, wrapping into the next row, V wraps to the top.
  always_comb begin
    step_h = cand_h_q + 8'd1;
    step_v = cand_v_q;
    if (cand_h_q == H_MAX_L) begin
      step_h = 8'd0;
      step_v = (cand_v_q == V_MAX_L) ? 7'd0 : cand_v_q + 7'd1;
    end
  end

  // This hit is the last cell of a full sweep.
  assign scan_done = scan_cnt_q == SCW'(CELLS - 1);
  assign fail_set  = ack_ok && fp.occ_hit && scan_mode_q && scan_done;
`else
  assign fail_set  = ack_ok && fp.occ_hit && !retry;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (fp.place_req) state_d = S_SAMPLE;
      S_SAMPLE: state_d = S_QUERY;
      S_QUERY: begin
        if (fp.occ_ack) begin
          if (!fp.occ_hit)      state_d = S_COMMIT;
`ifdef FOOD_SCAN_FALLBACK_EN
          else if (scan_mode_q) state_d = scan_done ? S_IDLE : S_SCAN;
          else                  state_d = retry ? S_SAMPLE : S_SCAN;
`else
          else                  state_d = retry ? S_SAMPLE : S_IDLE;
`endif
        end
      end
      S_COMMIT: state_d = S_IDLE;
`ifdef FOOD_SCAN_FALLBACK_EN
      S_SCAN:   state_d = S_QUERY;
`endif
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state so reset drops them without waiting for a clock.
  always_comb begin
    fp.rand_ce = 1'b0;
    fp.occ_req = 1'b0;
    fp.busy    = 1'b1;
    case (state_q)
      S_IDLE:   fp.busy    = 1'b0;
      S_SAMPLE: fp.rand_ce = 1'b1;
      S_QUERY:  fp.occ_req = 1'b1;
      default:  ;
    endcase
  end

  assign fp.occ_h      = cand_h_q;
  assign fp.occ_v      = cand_v_q;
  assign fp.food_h     = food_h_q;
  assign fp.food_v     = food_v_q;
  assign fp.food_valid = food_valid_q;
  assign fp.place_fail = place_fail_q;

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_h_q     <= '0;
      cand_v_q     <= '0;
      tries_q      <= '0;
      food_h_q     <= '0;
      food_v_q     <= '0;
      food_valid_q <= 1'b0;
      place_fail_q <= 1'b0;
`ifdef FOOD_SCAN_FALLBACK_EN
      scan_mode_q  <= 1'b0;
      scan_cnt_q   <= '0;
`endif
    end else begin
      // Lands together with the IDLE transition so the pulse lines up with BUSY falling.
      place_fail_q <= fail_set;

      if (accept) begin
        food_valid_q <= 1'b0;
        tries_q      <= '0;
`ifdef FOOD_SCAN_FALLBACK_EN
        scan_mode_q  <= 1'b0;
`endif
      end

      if (state_q == S_SAMPLE) begin
        cand_h_q <= fold_h;
        cand_v_q <= fold_v;
      end

      if (ack_ok && fp.occ_hit) tries_q <= tries_inc;

      if (state_q == S_COMMIT) begin
        food_h_q     <= cand_h_q;
        food_v_q     <= cand_v_q;
        food_valid_q <= 1'b1;
      end

`ifdef FOOD_SCAN_FALLBACK_EN
      if (ack_ok && fp.occ_hit) begin
        if (!scan_mode_q && !retry) begin
          scan_mode_q <= 1'b1;
          scan_cnt_q  <= '0;
        end else if (scan_mode_q) begin
          scan_cnt_q  <= scan_cnt_q + SCW'(1);
        end
      end

      if (state_q == S_SCAN) begin
        cand_h_q <= step_h;
        cand_v_q <= step_v;
      end
`endif
    end
  end

endmodule

// File: tb/tb_food_placer.sv
// ----------------------------------------------------------------------------
// tb_food_placer
//   Scoreboard bench for food_placer. Stimulus pushes expected queries and
//   expected placement results into queues; a monitor pops and compares them
//   whenever a query is acknowledged or BUSY falls. A behavioural responder
//   models the occupancy store with configurable ack delay and hit pattern.
// ----------------------------------------------------------------------------
module tb_food_placer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  food_placer_if fp_if();

  food_placer #(.H_MAX(159), .V_MAX(119), .MAX_TRIES(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fp    (fp_if)
  );

  typedef struct {
    logic [7:0] h;
    logic [6:0] v;
  } q_exp_t;

  typedef struct {
    logic       valid;
    logic [7:0] h;
    logic [6:0] v;
    logic       fail;
    int         ce;
    int         busy;
  } r_exp_t;

  q_exp_t qq[$];
  r_exp_t rq[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- random generator model ----------------
  logic [7:0] rh_tab[$];
  logic [6:0] rv_tab[$];
  int ridx = 0;

  task automatic drive_rand();
    fp_if.rand_h = (ridx < rh_tab.size()) ? rh_tab[ridx] : 8'h00;
    fp_if.rand_v = (ridx < rv_tab.size()) ? rv_tab[ridx] : 7'h00;
  endtask

  always begin
    @(negedge clk);
    if (fp_if.rand_ce) begin
      @(posedge clk);
      #1;
      ridx++;
      drive_rand();
    end
  end

  // ---------------- occupancy responder ----------------
  int ack_delay = 0;
  int rmode     = 0;   // 0: first n_hits queries hit; 1: all hit except (3,5)
  int n_hits    = 0;
  bit spurious  = 1'b0;
  int qidx      = 0;
  int wait_cnt  = 0;

  always @(negedge clk) begin
    if (fp_if.occ_req) begin
      if (wait_cnt >= ack_delay) begin
        fp_if.occ_ack = 1'b1;
        fp_if.occ_hit = (rmode == 0) ? (qidx < n_hits)
                                     : !(fp_if.occ_h == 8'd3 && fp_if.occ_v == 7'd5);
        qidx++;
        wait_cnt = 0;
      end else begin
        fp_if.occ_ack = 1'b0;
        fp_if.occ_hit = 1'b0;
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
      fp_if.occ_ack = spurious;
      fp_if.occ_hit = spurious;
    end
  end

  // ---------------- monitor ----------------
  logic       p_req, p_ack, p_busy;
  logic [7:0] p_h;
  logic [6:0] p_v;
  int busy_cnt, ce_cnt;

  initial begin
    p_req = 0; p_ack = 0; p_busy = 0; p_h = 0; p_v = 0;
    busy_cnt = 0; ce_cnt = 0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        p_req = 0; p_ack = 0; p_busy = 0; busy_cnt = 0; ce_cnt = 0;
      end else begin
        if (fp_if.occ_req && p_req && !p_ack)
          chk("occ_hold", {17'd0, fp_if.occ_h, fp_if.occ_v}, {17'd0, p_h, p_v});
        if (fp_if.occ_req && p_req && p_ack)
          chk("occ_req_gap", 32'd1, 32'd0);
        if (fp_if.occ_req && fp_if.occ_ack) begin
          if (qq.size() == 0) chk("query_unexpected", 32'd1, 32'd0);
          else begin
            q_exp_t e;
            e = qq.pop_front();
            chk("query_cell", {17'd0, fp_if.occ_h, fp_if.occ_v}, {17'd0, e.h, e.v});
          end
        end
        if (fp_if.busy) begin
          busy_cnt++;
          if (fp_if.rand_ce) ce_cnt++;
        end
        if (p_busy && !fp_if.busy) begin
          if (rq.size() == 0) chk("result_unexpected", 32'd1, 32'd0);
          else begin
            r_exp_t r;
            r = rq.pop_front();
            chk("food_valid", 32'(fp_if.food_valid), 32'(r.valid));
            chk("food_h",     32'(fp_if.food_h),     32'(r.h));
            chk("food_v",     32'(fp_if.food_v),     32'(r.v));
            chk("place_fail", 32'(fp_if.place_fail), 32'(r.fail));
            chk("rand_ce_cnt", 32'(ce_cnt),          32'(r.ce));
            if (r.busy >= 0) chk("busy_cycles", 32'(busy_cnt), 32'(r.busy));
          end
          busy_cnt = 0;
          ce_cnt   = 0;
        end else if (fp_if.place_fail) begin
          chk("fail_align", 32'd1, 32'd0);
        end
        p_req  = fp_if.occ_req;
        p_ack  = fp_if.occ_ack;
        p_h    = fp_if.occ_h;
        p_v    = fp_if.occ_v;
        p_busy = fp_if.busy;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic setup(input int dly, input int mode, input int hits, input bit spur);
    ack_delay = dly;
    rmode     = mode;
    n_hits    = hits;
    spurious  = spur;
    qidx      = 0;
  endtask

  task automatic tab_clear();
    rh_tab.delete();
    rv_tab.delete();
    ridx = 0;
  endtask

  task automatic tab_add(input logic [7:0] h, input logic [6:0] v);
    rh_tab.push_back(h);
    rv_tab.push_back(v);
    drive_rand();
  endtask

  task automatic push_q(input logic [7:0] h, input logic [6:0] v);
    q_exp_t e;
    e.h = h; e.v = v;
    qq.push_back(e);
  endtask

  task automatic push_r(input logic valid, input logic [7:0] h, input logic [6:0] v,
                        input logic fail, input int ce, input int busy);
    r_exp_t r;
    r.valid = valid; r.h = h; r.v = v; r.fail = fail; r.ce = ce; r.busy = busy;
    rq.push_back(r);
  endtask

  task automatic place();
    @(negedge clk);
    fp_if.place_req = 1'b1;
    @(negedge clk);
    fp_if.place_req = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (rq.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    #3;
    chk("done_in_time", 32'(rq.size()), 32'd0);
    chk("queries_used", 32'(qq.size()), 32'd0);
    rq.delete();
    qq.delete();
  endtask

  // Best-case single placement: no hit, immediate ack.
  task automatic one(input logic [7:0] rh, input logic [6:0] rv,
                     input logic [7:0] eh, input logic [6:0] ev);
    tab_clear();
    tab_add(rh, rv);
    push_q(eh, ev);
    push_r(1'b1, eh, ev, 1'b0, 1, 3);
    place();
    wait_done(50);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    fp_if.place_req = 1'b0;
    fp_if.occ_ack   = 1'b0;
    fp_if.occ_hit   = 1'b0;
    tab_clear();
    tab_add(8'h00, 7'h00);
    setup(0, 0, 0, 1'b0);

    // Reset state
    repeat (3) @(negedge clk);
    #3;
    chk("rst_busy",       32'(fp_if.busy),       32'd0);
    chk("rst_food_valid", 32'(fp_if.food_valid), 32'd0);
    chk("rst_occ_req",    32'(fp_if.occ_req),    32'd0);
    chk("rst_rand_ce",    32'(fp_if.rand_ce),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Best-case placement
    one(8'h20, 7'h10, 8'h20, 7'h10);

    // Folding: above range, exact maxima, exact span, all-ones
    one(8'hC8, 7'h7A, 8'h28, 7'h02);
    one(8'h9F, 7'h77, 8'h9F, 7'h77);
    one(8'hA0, 7'h78, 8'h00, 7'h00);
    one(8'hFF, 7'h7F, 8'h5F, 7'h07);

    // Two misses then a free cell, 3-cycle ack latency, request while busy ignored
    setup(3, 0, 2, 1'b0);
    tab_clear();
    tab_add(8'h11, 7'h22);
    tab_add(8'h33, 7'h44);
    tab_add(8'h55, 7'h66);
    push_q(8'h11, 7'h22);
    push_q(8'h33, 7'h44);
    push_q(8'h55, 7'h66);
    push_r(1'b1, 8'h55, 7'h66, 1'b0, 3, 16);
    place();
    repeat (4) @(negedge clk);
    place();
    wait_done(100);

    // Occupied everywhere except (3,5): random tries exhaust
    setup(0, 1, 0, 1'b0);
    tab_clear();
    for (int i = 0; i < 14; i++) begin
      tab_add(8'(10 + i), 7'(20 + i));
      push_q(8'(10 + i), 7'(20 + i));
    end
    tab_add(8'd158, 7'd4);
    push_q(8'd158, 7'd4);
`ifdef FOOD_SCAN_FALLBACK_EN
    push_q(8'd159, 7'd4);
    push_q(8'd0,   7'd5);
    push_q(8'd1,   7'd5);
    push_q(8'd2,   7'd5);
    push_q(8'd3,   7'd5);
    push_r(1'b1, 8'd3, 7'd5, 1'b0, 15, 41);
`else
    push_r(1'b0, 8'h55, 7'h66, 1'b1, 15, 30);
`endif
    place();
    wait_done(200);
    @(negedge clk);
    #3;
    chk("fail_one_cycle", 32'(fp_if.place_fail), 32'd0);

    // Stray acks outside a query are ignored
    setup(1, 0, 0, 1'b1);
    tab_clear();
    tab_add(8'h40, 7'h30);
    push_q(8'h40, 7'h30);
    push_r(1'b1, 8'h40, 7'h30, 1'b0, 1, 4);
    place();
    wait_done(50);
    setup(0, 0, 0, 1'b0);

    // Reset in the middle of a query
    setup(1000, 0, 0, 1'b0);
    tab_clear();
    tab_add(8'h70, 7'h40);
    place();
    begin
      int n = 0;
      while (!fp_if.occ_req && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    chk("reach_query", 32'(fp_if.occ_req), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_occ_req",    32'(fp_if.occ_req),    32'd0);
    chk("arst_rand_ce",    32'(fp_if.rand_ce),    32'd0);
    chk("arst_busy",       32'(fp_if.busy),       32'd0);
    chk("arst_food",       {17'd0, fp_if.food_h, fp_if.food_v}, 32'd0);
    chk("arst_food_valid", 32'(fp_if.food_valid), 32'd0);
    chk("arst_occ_cell",   {17'd0, fp_if.occ_h, fp_if.occ_v}, 32'd0);
    chk("arst_place_fail", 32'(fp_if.place_fail), 32'd0);
    qq.delete();
    rq.delete();
    setup(0, 0, 0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Normal operation after reset
    one(8'h20, 7'h10, 8'h20, 7'h10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
